wrr_arbiter_hs: RTL

- Parametrised, handshaked weighted round-robin arbiter for the memory-manager request path.
- Grants one of NUM_REQ requesters per transaction and holds the grant until the grantee signals completion.
- Weights are runtime-programmable and requesters without a request are skipped in one cycle (work-conserving).
- Sits between the per-port request front-ends and the shared memory controller.

---
 rtl/wrr_arbiter_hs_pkg.sv | 10 +
 rtl/wrr_arbiter_hs_if.sv | 25 ++
 rtl/wrr_arbiter_hs_rr_pick.sv | 29 ++
 rtl/wrr_arbiter_hs.sv | 99 +++++++++
 4 files changed

// File: rtl/wrr_arbiter_hs_pkg.sv
// wrr_pkg: shared state encoding and index-width helper for the weighted round-robin arbiter.
package wrr_pkg;

    typedef enum logic {WRR_IDLE, WRR_GRANT} wrr_state_e;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_hs_if.sv
// wrr_arbiter_hs_if: request/grant handshake and weight-programming bundle of the arbiter.
interface wrr_arbiter_hs_if import wrr_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
);
    logic [NUM_REQ-1:0]  req_i;
    logic                done_i;
    logic                wgt_we_i;
    logic [IDX_W-1:0]    wgt_idx_i;
    logic [WEIGHT_W-1:0] wgt_data_i;
    logic [NUM_REQ-1:0]  gnt_o;
    logic                gnt_valid_o;
    logic [IDX_W-1:0]    gnt_idx_o;

    modport slave (
        input  req_i, done_i, wgt_we_i, wgt_idx_i, wgt_data_i,
        output gnt_o, gnt_valid_o, gnt_idx_o
    );

    modport master (
        output req_i, done_i, wgt_we_i, wgt_idx_i, wgt_data_i,
        input  gnt_o, gnt_valid_o, gnt_idx_o
    );
endinterface

// File: rtl/wrr_arbiter_hs_rr_pick.sv
// rr_pick: combinational circular first-one finder starting at start_i, any width >= 2.
module rr_pick import wrr_pkg::*; #(
    parameter int WIDTH  = 4,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o
);
    logic [IDX_W-1:0] j;

    // Modulo wrap keeps the scan inside 0..WIDTH-1 for non-power-of-2 widths.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        j        = '0;
        for (int k = 0; k < WIDTH; k++) begin
            j = IDX_W'((int'(start_i) + k) % WIDTH);
            if (!found_o && vec_i[j]) begin
                found_o     = 1'b1;
                idx_o       = j;
                onehot_o[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wrr_arbiter_hs.sv
// wrr_arbiter_hs: handshaked weighted round-robin arbiter; grant is held until done_i,
// with same-cycle re-arbitration so back-to-back grants have no dead cycle.
module wrr_arbiter_hs import wrr_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4,
    parameter logic [NUM_REQ*WEIGHT_W-1:0] DEFAULT_WEIGHTS = {NUM_REQ{WEIGHT_W'(1)}},
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input logic clk_i,
    input logic rst_ni,
    wrr_arbiter_hs_if.slave bus
);
    logic [WEIGHT_W-1:0] wgt_q [NUM_REQ];
    wrr_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d, winner_q, winner_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic                vld_q, vld_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  elig, pick_oh;
    logic                found, rollover, arb;
    logic [IDX_W-1:0]    pick, ptr_e, next_ptr;
    logic [WEIGHT_W-1:0] cred_e, pick_wgt;
    logic                vld_e;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) elig[i] = bus.req_i[i] && (wgt_q[i] != '0);
    end

    always_comb begin
        pick_wgt = '0;
        for (int i = 0; i < NUM_REQ; i++) pick_wgt = pick_wgt | (pick_oh[i] ? wgt_q[i] : '0);
    end

    // Effective pointer/credit as seen after the current grantee completes.
    always_comb begin
        next_ptr = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        rollover = (state_q == WRR_GRANT) && (credit_q <= WEIGHT_W'(1));
        cred_e   = (state_q == WRR_GRANT && !rollover) ? credit_q - WEIGHT_W'(1) : credit_q;
        ptr_e    = rollover ? next_ptr : ptr_q;
        vld_e    = rollover ? 1'b0 : vld_q;
        arb      = (state_q == WRR_IDLE) || bus.done_i;
    end

    rr_pick #(.WIDTH(NUM_REQ)) u_pick (
        .vec_i    (elig),
        .start_i  (ptr_e),
        .found_o  (found),
        .idx_o    (pick),
        .onehot_o (pick_oh)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        winner_d = winner_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        vld_d    = vld_q;
        if (arb) begin
            state_d  = found ? WRR_GRANT : WRR_IDLE;
            gnt_d    = found ? pick_oh : '0;
            winner_d = found ? pick : winner_q;
            ptr_d    = ptr_e;
            credit_d = cred_e;
            vld_d    = vld_e;
            if (found && !(pick == ptr_e && vld_e)) begin
                credit_d = pick_wgt;
                vld_d    = 1'b1;
                ptr_d    = pick;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WRR_IDLE;
            gnt_q    <= '0;
            winner_q <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            vld_q    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) wgt_q[i] <= DEFAULT_WEIGHTS[i*WEIGHT_W +: WEIGHT_W];
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            vld_q    <= vld_d;
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.wgt_we_i && bus.wgt_idx_i == IDX_W'(i)) wgt_q[i] <= bus.wgt_data_i;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = |gnt_q;
    assign bus.gnt_idx_o   = winner_q;
endmodule
